paddle_ctl: RTL and testbench
=============================

PADDLE_CTL -- requirements
Module: paddle_ctl

Interface
REQ-001 Parameter Y_MAX, default 688, largest legal paddle top row (768 - 80).
REQ-002 Parameter Y_INIT, default 344, paddle top row after reset.
REQ-003 Parameter SPEED_MIN, default 2, initial step in px/frame.
REQ-004 Parameter SPEED_MAX, default 8, step ceiling in px/frame.
REQ-005 pclk  in  1  pixel clock; the block's only clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 vblnk_in  in  1  vertical blanking from the timing chain.
REQ-008 btn_up  in  1  asynchronous up button, active high.
REQ-009 btn_dn  in  1  asynchronous down button, active high.
REQ-010 enable  in  1  movement enable; low freezes the paddle.
REQ-011 y_pos  out  12  paddle top row, fed to the rectangle drawer.
REQ-012 frame_tick  out  1  one-cycle pulse marking each frame update.
REQ-013 at_top  out  1  high when y_pos == 0.
REQ-014 at_bottom  out  1  high when y_pos == Y_MAX.
REQ-015 The block SHALL have exactly one clock, pclk, and an asynchronous, active-high reset, rst.

Function
REQ-016 btn_up and btn_dn SHALL each pass through a two-flop synchronizer (up_s, dn_s) before any use.
REQ-017 The block SHALL register vblnk_in into vblnk_q; a rising edge is vblnk_in=1 while vblnk_q=0.
REQ-018 On the edge where a rising edge is detected, frame_tick SHALL go high for exactly one cycle; all other state SHALL update only on that same edge.
REQ-019 y_pos SHALL change only on frame_tick edges, and SHALL stay stable through active video.
REQ-020 Each tick SHALL store up_s/dn_s into up_prev/dn_prev.
REQ-021 Debounced cmd_up = up_s AND up_prev; debounced cmd_dn = dn_s AND dn_prev. A press therefore needs two consecutive ticks to register.
REQ-022 FSM states are IDLE, UP and DOWN; transitions occur only on ticks.
REQ-023 The next state is chosen as follows:
  - enable=0 -> IDLE.
  - cmd_up and cmd_dn both high -> IDLE.
  - cmd_up only -> UP.
  - cmd_dn only -> DOWN.
  - neither -> IDLE.
REQ-024 speed (4 bits) SHALL be SPEED_MIN on any tick whose next state differs from the current state or is IDLE.
REQ-025 When next state equals current state (UP or DOWN), speed SHALL become min(speed+1, SPEED_MAX).
REQ-026 On a tick with next state UP, y_pos SHALL become max(y_pos - new speed, 0); the subtraction is 13-bit signed, with no wrap.
REQ-027 On a tick with next state DOWN, y_pos SHALL become min(y_pos + new speed, Y_MAX); the addition is 13-bit, with no wrap.
REQ-028 When next state is IDLE, y_pos SHALL hold.
REQ-029 If the paddle is at a bound and pushed further, y_pos SHALL hold at the bound while the state stays UP/DOWN and speed keeps saturating.
REQ-030 at_top and at_bottom SHALL be registered, updated with y_pos, and consistent with y_pos every cycle.
REQ-031 vblnk_in held high for many cycles SHALL produce only one tick; a vblnk_in glitch shorter than one cycle between samples SHALL produce no tick.

Reset
REQ-032 While rst=1, and asynchronously on its assertion, the following SHALL hold:
  - y_pos=Y_INIT.
  - FSM=IDLE.
  - speed=SPEED_MIN.
  - frame_tick=0, at_top=0, at_bottom=0.
  - all synchronizer, prev and vblnk_q flops=0.
REQ-033 Reset asserted mid-movement SHALL discard state immediately.
REQ-034 The first tick after release SHALL see up_prev=dn_prev=0, so no movement is possible before the second tick.

Verification
REQ-035 Reset, then 3 vblnk rising edges with no buttons -> y_pos=344 throughout, frame_tick exactly 3 single-cycle pulses, each 1 cycle after the vblnk rise.
REQ-036 btn_dn held over 8 ticks from y_pos=344 -> tick1 no move; tick2 +2, then +3,+4,+5,+6,+7,+8 -> y_pos=379.
REQ-037 y_pos=684, btn_dn held with speed 8 -> y_pos=688, at_bottom=1; further ticks hold 688.
REQ-038 btn_up and btn_dn both held -> state IDLE, y_pos unchanged; release dn -> movement up begins at speed 2 on the second tick.
REQ-039 enable=0 while moving up at speed 6 -> next tick y_pos unchanged, speed=2; enable=1 -> movement resumes at speed 2.
REQ-040 rst pulsed mid-frame while y_pos=100 in state DOWN -> y_pos=344 immediately without waiting for pclk; no frame_tick until the next vblnk rise.

Source files
------------

// File: rtl/paddle_ctl.sv
// Paddle position controller: synchronizes and debounces the up/down buttons once per
// frame, then steps the paddle row with an accelerating speed that is clamped to the screen.
module paddle_ctl #(
  parameter int Y_MAX     = 688,
  parameter int Y_INIT    = 344,
  parameter int SPEED_MIN = 2,
  parameter int SPEED_MAX = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        enable,
  output logic [11:0] y_pos,
  output logic        frame_tick,
  output logic        at_top,
  output logic        at_bottom,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_speed
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  localparam logic [11:0] Y_MAX_L  = 12'(Y_MAX);
  localparam logic [11:0] Y_INIT_L = 12'(Y_INIT);
  localparam logic [12:0] Y_MAX_W  = 13'(Y_MAX);
  localparam logic [3:0]  SPD_MIN  = 4'(SPEED_MIN);
  localparam logic [3:0]  SPD_MAX  = 4'(SPEED_MAX);

  logic        up_meta_q, up_s_q, dn_meta_q, dn_s_q;
  logic        vblnk_q;
  logic        up_prev_q, up_prev_d, dn_prev_q, dn_prev_d;
  state_t      state_q, state_d, state_nxt;
  logic [3:0]  speed_q, speed_d, speed_new, speed_inc;
  logic [11:0] y_q, y_d, y_new;
  logic        tick_q, tick_d;
  logic        at_top_q, at_top_d, at_bot_q, at_bot_d;
  logic        cmd_up, cmd_dn;
  logic signed [12:0] diff;
  logic [12:0] sum;

  always_comb begin
    tick_d = vblnk_in & ~vblnk_q;
    cmd_up = up_s_q & up_prev_q;
    cmd_dn = dn_s_q & dn_prev_q;

    if (!enable)              state_nxt = IDLE;
    else if (cmd_up && cmd_dn) state_nxt = IDLE;
    else if (cmd_up)          state_nxt = UP;
    else if (cmd_dn)          state_nxt = DOWN;
    else                      state_nxt = IDLE;

    speed_inc = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 4'd1;
    // Speed only builds up while the same direction is held across consecutive ticks.
    speed_new = (state_nxt == state_q && state_nxt != IDLE) ? speed_inc : SPD_MIN;

    diff = $signed({1'b0, y_q}) - $signed({9'd0, speed_new});
    sum  = {1'b0, y_q} + {9'd0, speed_new};
    case (state_nxt)
      UP:      y_new = diff[12] ? 12'd0 : diff[11:0];
      DOWN:    y_new = (sum > Y_MAX_W) ? Y_MAX_L : sum[11:0];
      default: y_new = y_q;
    endcase

    state_d   = state_q;
    speed_d   = speed_q;
    y_d       = y_q;
    up_prev_d = up_prev_q;
    dn_prev_d = dn_prev_q;
    at_top_d  = at_top_q;
    at_bot_d  = at_bot_q;
    if (tick_d) begin
      state_d   = state_nxt;
      speed_d   = speed_new;
      y_d       = y_new;
      up_prev_d = up_s_q;
      dn_prev_d = dn_s_q;
      at_top_d  = (y_new == 12'd0);
      at_bot_d  = (y_new == Y_MAX_L);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      up_meta_q <= 1'b0;
      up_s_q    <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_s_q    <= 1'b0;
      vblnk_q   <= 1'b0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      state_q   <= IDLE;
      speed_q   <= SPD_MIN;
      y_q       <= Y_INIT_L;
      tick_q    <= 1'b0;
      at_top_q  <= 1'b0;
      at_bot_q  <= 1'b0;
    end else begin
      up_meta_q <= btn_up;
      up_s_q    <= up_meta_q;
      dn_meta_q <= btn_dn;
      dn_s_q    <= dn_meta_q;
      vblnk_q   <= vblnk_in;
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
      state_q   <= state_d;
      speed_q   <= speed_d;
      y_q       <= y_d;
      tick_q    <= tick_d;
      at_top_q  <= at_top_d;
      at_bot_q  <= at_bot_d;
    end
  end

  assign y_pos      = y_q;
  assign frame_tick = tick_q;
  assign at_top     = at_top_q;
  assign at_bottom  = at_bot_q;
  assign dbg_state  = state_q;
  assign dbg_speed  = speed_q;

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed bench for paddle_ctl: frame ticks, debounce latency, acceleration,
// clamping at both bounds, both-button/enable behaviour and asynchronous reset.
module tb_paddle_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in, btn_up, btn_dn, enable;
  logic [11:0] y_pos;
  logic        frame_tick, at_top, at_bottom;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_speed;

  int tests_run    = 0;
  int tests_failed = 0;
  int tick_cnt     = 0;

  paddle_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .btn_up(btn_up), .btn_dn(btn_dn),
    .enable(enable), .y_pos(y_pos), .frame_tick(frame_tick), .at_top(at_top),
    .at_bottom(at_bottom), .dbg_state(dbg_state), .dbg_speed(dbg_speed)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (frame_tick === 1'b1) tick_cnt++;

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge pclk);
      vblnk_in = 1'b1;
      repeat (3) @(negedge pclk);
      vblnk_in = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    tests_run++;
    if (y_pos !== 12'd344 || frame_tick !== 1'b0 || at_top !== 1'b0 || at_bottom !== 1'b0 ||
        dbg_state !== 2'd0 || dbg_speed !== 4'd2) begin
      tests_failed++;
      $display("FAIL reset: y=%0d tick=%b top=%b bot=%b st=%0d spd=%0d, want 344 0 0 0 0 2",
               y_pos, frame_tick, at_top, at_bottom, dbg_state, dbg_speed);
    end
    repeat (2) @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_idle_frames;
    int t0;
    t0 = tick_cnt;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge pclk);
      vblnk_in = 1'b1;
      @(negedge pclk);
      tests_run++;
      if (frame_tick !== 1'b1) begin
        tests_failed++;
        $display("FAIL tick_pulse_hi[%0d]: got %b want 1", i, frame_tick);
      end
      @(negedge pclk);
      tests_run++;
      if (frame_tick !== 1'b0 || y_pos !== 12'd344) begin
        tests_failed++;
        $display("FAIL tick_pulse_lo[%0d]: tick=%b y=%0d want 0 344", i, frame_tick, y_pos);
      end
      vblnk_in = 1'b0;
    end
    tests_run++;
    if (tick_cnt - t0 !== 3) begin
      tests_failed++;
      $display("FAIL tick_count: got %0d want 3", tick_cnt - t0);
    end
    // long vblank gives one tick; sub-cycle glitch gives none
    t0 = tick_cnt;
    @(negedge pclk);
    vblnk_in = 1'b1;
    repeat (20) @(negedge pclk);
    vblnk_in = 1'b0;
    repeat (3) @(negedge pclk);
    #1 vblnk_in = 1'b1;
    #2 vblnk_in = 1'b0;
    repeat (3) @(negedge pclk);
    tests_run++;
    if (tick_cnt - t0 !== 1) begin
      tests_failed++;
      $display("FAIL long_vblank_glitch: got %0d ticks want 1", tick_cnt - t0);
    end
  endtask

  task automatic test_move_down;
    btn_dn = 1'b1;
    frame(1);
    tests_run++;
    if (y_pos !== 12'd344) begin
      tests_failed++;
      $display("FAIL down_tick1: got %0d want 344", y_pos);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd346 || dbg_state !== 2'd2 || dbg_speed !== 4'd2) begin
      tests_failed++;
      $display("FAIL down_tick2: y=%0d st=%0d spd=%0d want 346 2 2", y_pos, dbg_state, dbg_speed);
    end
    frame(6);
    tests_run++;
    if (y_pos !== 12'd379 || dbg_speed !== 4'd8) begin
      tests_failed++;
      $display("FAIL down_tick8: y=%0d spd=%0d want 379 8", y_pos, dbg_speed);
    end
  endtask

  task automatic test_bottom;
    frame(38);
    tests_run++;
    if (y_pos !== 12'd683 || at_bottom !== 1'b0) begin
      tests_failed++;
      $display("FAIL near_bottom: y=%0d bot=%b want 683 0", y_pos, at_bottom);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd688 || at_bottom !== 1'b1 || at_top !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_bottom: y=%0d bot=%b top=%b want 688 1 0", y_pos, at_bottom, at_top);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd688 || at_bottom !== 1'b1 || dbg_speed !== 4'd8 || dbg_state !== 2'd2) begin
      tests_failed++;
      $display("FAIL hold_bottom: y=%0d bot=%b spd=%0d st=%0d want 688 1 8 2",
               y_pos, at_bottom, dbg_speed, dbg_state);
    end
  endtask

  task automatic test_both_buttons;
    btn_up = 1'b1;
    frame(2);
    tests_run++;
    if (y_pos !== 12'd688 || dbg_state !== 2'd0 || dbg_speed !== 4'd2) begin
      tests_failed++;
      $display("FAIL both_idle: y=%0d st=%0d spd=%0d want 688 0 2", y_pos, dbg_state, dbg_speed);
    end
    btn_dn = 1'b0;
    frame(1);
    tests_run++;
    if (y_pos !== 12'd686 || dbg_state !== 2'd1 || dbg_speed !== 4'd2 || at_bottom !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_dn: y=%0d st=%0d spd=%0d bot=%b want 686 1 2 0",
               y_pos, dbg_state, dbg_speed, at_bottom);
    end
  endtask

  task automatic test_enable;
    frame(4);
    tests_run++;
    if (y_pos !== 12'd668 || dbg_speed !== 4'd6) begin
      tests_failed++;
      $display("FAIL up_speed6: y=%0d spd=%0d want 668 6", y_pos, dbg_speed);
    end
    enable = 1'b0;
    frame(1);
    tests_run++;
    if (y_pos !== 12'd668 || dbg_speed !== 4'd2 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL disabled: y=%0d spd=%0d st=%0d want 668 2 0", y_pos, dbg_speed, dbg_state);
    end
    enable = 1'b1;
    frame(1);
    tests_run++;
    if (y_pos !== 12'd666 || dbg_speed !== 4'd2 || dbg_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL reenabled: y=%0d spd=%0d st=%0d want 666 2 1", y_pos, dbg_speed, dbg_state);
    end
  endtask

  task automatic test_top;
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    frame(8);
    tests_run++;
    if (y_pos !== 12'd309 || dbg_speed !== 4'd8) begin
      tests_failed++;
      $display("FAIL up_tick8: y=%0d spd=%0d want 309 8", y_pos, dbg_speed);
    end
    frame(38);
    tests_run++;
    if (y_pos !== 12'd5 || at_top !== 1'b0) begin
      tests_failed++;
      $display("FAIL near_top: y=%0d top=%b want 5 0", y_pos, at_top);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd0 || at_top !== 1'b1 || at_bottom !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_top: y=%0d top=%b bot=%b want 0 1 0", y_pos, at_top, at_bottom);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd0 || at_top !== 1'b1 || dbg_speed !== 4'd8 || dbg_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL hold_top: y=%0d top=%b spd=%0d st=%0d want 0 1 8 1",
               y_pos, at_top, dbg_speed, dbg_state);
    end
  endtask

  task automatic test_async_reset;
    int t0;
    btn_up = 1'b0;
    btn_dn = 1'b1;
    frame(3);
    tests_run++;
    if (y_pos !== 12'd5 || dbg_state !== 2'd2) begin
      tests_failed++;
      $display("FAIL pre_reset_down: y=%0d st=%0d want 5 2", y_pos, dbg_state);
    end
    @(negedge pclk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (y_pos !== 12'd344 || dbg_state !== 2'd0 || dbg_speed !== 4'd2 || at_top !== 1'b0 ||
        frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: y=%0d st=%0d spd=%0d top=%b tick=%b want 344 0 2 0 0",
               y_pos, dbg_state, dbg_speed, at_top, frame_tick);
    end
    @(negedge pclk);
    rst = 1'b0;
    t0 = tick_cnt;
    repeat (6) @(negedge pclk);
    tests_run++;
    if (tick_cnt !== t0) begin
      tests_failed++;
      $display("FAIL no_tick_after_reset: got %0d ticks want 0", tick_cnt - t0);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd344) begin
      tests_failed++;
      $display("FAIL first_tick_after_reset: y=%0d want 344", y_pos);
    end
    frame(1);
    tests_run++;
    if (y_pos !== 12'd346) begin
      tests_failed++;
      $display("FAIL second_tick_after_reset: y=%0d want 346", y_pos);
    end
  endtask

  initial begin
    rst = 1'b1;
    vblnk_in = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    enable = 1'b1;
    test_reset();
    test_idle_frames();
    test_move_down();
    test_bottom();
    test_both_buttons();
    test_enable();
    test_top();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
